// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 receiver.
// Imported by the interface, the line filter and the receiver top.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } ps2_state_t;

   localparam int   DATA_BITS   = 8;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;
   localparam logic ODD_PARITY  = 1'b1;

   // Parity bit that makes the total count of ones in data plus parity odd.
   function automatic logic odd_parity_of(input logic [DATA_BITS-1:0] d);
      return ~(^d);
   endfunction

endpackage

// File: rtl/ps2_rx_if.sv
// Byte stream from the PS/2 receiver to its consumer: valid/ready handshake plus error pulses.
interface ps2_rx_if;
   import ps2_pkg::*;

   logic [DATA_BITS-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic                 parity_err;
   logic                 frame_err;
   logic                 timeout_err;
   logic                 overrun;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready,
      output parity_err,
      output frame_err,
      output timeout_err,
      output overrun
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready,
      input  parity_err,
      input  frame_err,
      input  timeout_err,
      input  overrun
   );

endinterface

// File: rtl/ps2_line_filter.sv
// Synchronises the raw PS/2 lines, deglitches the clock, and emits a one-cycle fall event
// together with a data sample delayed by the same amount as the filtered clock.
module ps2_line_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2_clk,
   input  logic ps2_dat,
   output logic dat_s,
   output logic fall
);

   logic [1:0]               clk_sync;
   logic [1:0]               dat_sync;
   logic                     clk_f;
   logic [3:0]               cnt;
   logic [FILTER_CYCLES-1:0] dat_dly;

   // Both chains preset to 1 so that reset looks like an idle line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
      end
   end

   // clk_f follows the synchronised clock only after FILTER_CYCLES samples in a row disagree
   // with it; the fall pulse is raised in the same update that drops clk_f.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_f <= 1'b1;
         cnt   <= '0;
         fall  <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_sync[1] == clk_f) begin
            cnt <= '0;
         end else if (cnt == 4'(FILTER_CYCLES - 1)) begin
            clk_f <= clk_sync[1];
            cnt   <= '0;
            fall  <= clk_f;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

   // The data line gets FILTER_CYCLES extra flops so dat_s lines up with clk_f.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dat_dly <= '1;
      end else begin
         dat_dly[0] <= dat_sync[1];
         for (int i = 1; i < FILTER_CYCLES; i++) begin
            dat_dly[i] <= dat_dly[i-1];
         end
      end
   end

   assign dat_s = dat_dly[FILTER_CYCLES-1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: deserialises start/8 data/odd parity/stop frames and hands good bytes
// to a one-entry holding register with a valid/ready interface and error pulses.
module ps2_rx
   import ps2_pkg::*;
#(
   parameter int FILTER_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 2000
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     ps2_clk,
   input  logic     ps2_dat,
   ps2_rx_if.master bus
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic                 dat_s;
   logic                 fall;
   ps2_state_t           state;
   logic [2:0]           bitcnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 acc;
   logic                 parity_ok;
   logic [TW-1:0]        tmo;
   logic [DATA_BITS-1:0] hold_data;
   logic                 hold_valid;
   logic                 parity_err_q;
   logic                 frame_err_q;
   logic                 timeout_err_q;
   logic                 overrun_q;

   ps2_line_filter #(
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter (
      .clk     (clk),
      .reset   (reset),
      .ps2_clk (ps2_clk),
      .ps2_dat (ps2_dat),
      .dat_s   (dat_s),
      .fall    (fall)
   );

   // Frame FSM, inactivity timer and holding register share one block so the consumer
   // handshake and a same-cycle load resolve with the load taking priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         bitcnt        <= '0;
         shreg         <= '0;
         acc           <= 1'b0;
         parity_ok     <= 1'b0;
         tmo           <= '0;
         hold_data     <= '0;
         hold_valid    <= 1'b0;
         parity_err_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         parity_err_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         overrun_q     <= 1'b0;

         if (hold_valid && bus.out_ready) begin
            hold_valid <= 1'b0;
         end

         if (fall) begin
            tmo <= '0;
            case (state)
               IDLE: begin
                  if (dat_s == START_LEVEL) begin
                     state  <= DATA;
                     bitcnt <= '0;
                     acc    <= 1'b0;
                  end
               end
               DATA: begin
                  shreg  <= {dat_s, shreg[DATA_BITS-1:1]};
                  acc    <= acc ^ dat_s;
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'(DATA_BITS - 1)) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  parity_ok <= ((acc ^ dat_s) == ODD_PARITY);
                  state     <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (dat_s != STOP_LEVEL) begin
                     frame_err_q <= 1'b1;
                  end else if (!parity_ok) begin
                     parity_err_q <= 1'b1;
                  end else if (!hold_valid || bus.out_ready) begin
                     hold_data  <= shreg;
                     hold_valid <= 1'b1;
                  end else begin
                     overrun_q <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
               tmo           <= '0;
               state         <= IDLE;
               timeout_err_q <= 1'b1;
            end else begin
               tmo <= tmo + 1'b1;
            end
         end
      end
   end

   assign bus.out_data    = hold_data;
   assign bus.out_valid   = hold_valid;
   assign bus.parity_err  = parity_err_q;
   assign bus.frame_err   = frame_err_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: drives PS/2 frames at an 80 us bit period on a 1 MHz clock
// and compares received bytes and error pulses against a frame-level reference model.
`timescale 1ns/1ns
module tb_ps2_rx;

   localparam int US = 1000;

   logic clk;
   logic reset;
   logic ps2_clk;
   logic ps2_dat;

   ps2_rx_if rx_bus ();

   ps2_rx u_dut (
      .clk     (clk),
      .reset   (reset),
      .ps2_clk (ps2_clk),
      .ps2_dat (ps2_dat),
      .bus     (rx_bus.master)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] rx_q[$];
   int         n_par = 0;
   int         n_frm = 0;
   int         n_tmo = 0;
   int         n_ovr = 0;

   initial clk = 1'b0;
   always #(US/2) clk = ~clk;

   // Observes the consumer side away from the active edge.
   always @(negedge clk) begin
      if (rx_bus.out_valid && rx_bus.out_ready) rx_q.push_back(rx_bus.out_data);
      if (rx_bus.parity_err)  n_par++;
      if (rx_bus.frame_err)   n_frm++;
      if (rx_bus.timeout_err) n_tmo++;
      if (rx_bus.overrun)     n_ovr++;
   end

   initial begin
      #(200_000 * US);
      $display("[TB] FAIL watchdog expired before the sequence completed");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [10:0] make_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic par;
      par = ~(^d);
      if (bad_par) par = ~par;
      return {(bad_stop ? 1'b0 : 1'b1), par, d, 1'b0};
   endfunction

   // Reference outcome of a frame: 0 good, 1 frame error, 2 parity error.
   function automatic int frame_outcome(input logic [10:0] f);
      int ones;
      ones = 0;
      for (int i = 1; i <= 9; i++) ones += int'(f[i]);
      if (f[10] == 1'b0) return 1;
      if (ones % 2 == 0) return 2;
      return 0;
   endfunction

   // Sends the first nbits of a frame; a 2 us low glitch opens the high phase of glitch_bit.
   task automatic send_bits(input logic [10:0] f, input int nbits, input int glitch_bit);
      for (int i = 0; i < nbits; i++) begin
         if (i == glitch_bit) begin
            #(5*US)  ps2_clk = 1'b0;
            #(2*US)  ps2_clk = 1'b1;
            #(13*US);
         end else begin
            #(20*US);
         end
         ps2_dat = f[i];
         #(20*US) ps2_clk = 1'b0;
         #(40*US) ps2_clk = 1'b1;
      end
      #(20*US) ps2_dat = 1'b1;
      #(40*US);
   endtask

   task automatic test_reset();
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      rx_bus.out_ready = 1'b1;
      reset = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rx_bus.out_valid, rx_bus.out_data, rx_bus.parity_err, rx_bus.frame_err,
           rx_bus.timeout_err, rx_bus.overrun} !== 13'h0) begin
         errors++;
         $display("[TB] FAIL reset_outputs got valid=%b data=%h pe=%b fe=%b te=%b ov=%b exp all 0",
                  rx_bus.out_valid, rx_bus.out_data, rx_bus.parity_err, rx_bus.frame_err,
                  rx_bus.timeout_err, rx_bus.overrun);
      end
      reset = 1'b0;
      repeat (20) @(posedge clk);
   endtask

   task automatic test_back_to_back();
      int base, errs0;
      logic [7:0] got;
      base  = rx_q.size();
      errs0 = n_par + n_frm + n_tmo + n_ovr;
      for (int b = 0; b < 16; b++) send_bits(make_frame(8'(b), 1'b0, 1'b0), 11, -1);
      checks++;
      if (rx_q.size() - base !== 16) begin
         errors++;
         $display("[TB] FAIL seq_count got %0d exp 16", rx_q.size() - base);
      end
      for (int b = 0; b < 16; b++) begin
         got = (base + b < rx_q.size()) ? rx_q[base + b] : 8'hxx;
         checks++;
         if (got !== 8'(b)) begin
            errors++;
            $display("[TB] FAIL seq_byte%0d got %h exp %h", b, got, 8'(b));
         end
      end
      checks++;
      if (n_par + n_frm + n_tmo + n_ovr - errs0 !== 0) begin
         errors++;
         $display("[TB] FAIL seq_errors got %0d exp 0", n_par + n_frm + n_tmo + n_ovr - errs0);
      end
   endtask

   task automatic test_parity_error();
      int base, p0;
      logic [7:0] got;
      base = rx_q.size();
      p0   = n_par;
      send_bits(make_frame(8'h5A, 1'b1, 1'b0), 11, -1);
      checks++;
      if (n_par - p0 !== 1 || rx_q.size() !== base) begin
         errors++;
         $display("[TB] FAIL parity_bad got pe=%0d bytes=%0d exp pe=1 bytes=0", n_par - p0, rx_q.size() - base);
      end
      send_bits(make_frame(8'h5A, 1'b0, 1'b0), 11, -1);
      got = (rx_q.size() == base + 1) ? rx_q[base] : 8'hxx;
      checks++;
      if (got !== 8'h5A || n_par - p0 !== 1) begin
         errors++;
         $display("[TB] FAIL parity_recover got %h pe=%0d exp 5a pe=1", got, n_par - p0);
      end
   endtask

   task automatic test_frame_error();
      int base, f0, p0;
      base = rx_q.size();
      f0   = n_frm;
      p0   = n_par;
      send_bits(make_frame(8'h33, 1'b0, 1'b1), 11, -1);
      checks++;
      if (n_frm - f0 !== 1 || n_par - p0 !== 0 || rx_q.size() !== base) begin
         errors++;
         $display("[TB] FAIL frame_bad got fe=%0d pe=%0d bytes=%0d exp fe=1 pe=0 bytes=0",
                  n_frm - f0, n_par - p0, rx_q.size() - base);
      end
   endtask

   task automatic test_timeout();
      int base, t0;
      logic [7:0] got;
      base = rx_q.size();
      t0   = n_tmo;
      send_bits(make_frame(8'hFF, 1'b0, 1'b0), 5, -1);
      #(3000*US);
      checks++;
      if (n_tmo - t0 !== 1 || rx_q.size() !== base) begin
         errors++;
         $display("[TB] FAIL timeout got te=%0d bytes=%0d exp te=1 bytes=0", n_tmo - t0, rx_q.size() - base);
      end
      send_bits(make_frame(8'hA5, 1'b0, 1'b0), 11, -1);
      got = (rx_q.size() == base + 1) ? rx_q[base] : 8'hxx;
      checks++;
      if (got !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL timeout_recover got %h exp a5", got);
      end
   endtask

   task automatic test_overrun();
      int base, o0;
      logic [7:0] got;
      base = rx_q.size();
      o0   = n_ovr;
      @(posedge clk);
      #1 rx_bus.out_ready = 1'b0;
      send_bits(make_frame(8'h01, 1'b0, 1'b0), 11, -1);
      checks++;
      if (rx_bus.out_valid !== 1'b1 || rx_bus.out_data !== 8'h01 || n_ovr - o0 !== 0) begin
         errors++;
         $display("[TB] FAIL ovr_first got valid=%b data=%h ov=%0d exp 1 01 0", rx_bus.out_valid, rx_bus.out_data, n_ovr - o0);
      end
      send_bits(make_frame(8'h02, 1'b0, 1'b0), 11, -1);
      checks++;
      if (rx_bus.out_valid !== 1'b1 || rx_bus.out_data !== 8'h01 || n_ovr - o0 !== 1) begin
         errors++;
         $display("[TB] FAIL ovr_second got valid=%b data=%h ov=%0d exp 1 01 1", rx_bus.out_valid, rx_bus.out_data, n_ovr - o0);
      end
      @(posedge clk);
      #1 rx_bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #100;
      got = (rx_q.size() == base + 1) ? rx_q[base] : 8'hxx;
      checks++;
      if (got !== 8'h01 || rx_bus.out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovr_drain got data=%h handshakes=%0d valid=%b exp 01 1 0", got, rx_q.size() - base, rx_bus.out_valid);
      end
      repeat (10) @(posedge clk);
      checks++;
      if (rx_q.size() !== base + 1) begin
         errors++;
         $display("[TB] FAIL ovr_single got %0d handshakes exp 1", rx_q.size() - base);
      end
   endtask

   task automatic test_glitch_and_reset();
      int base, errs0, t0;
      logic [7:0] got;
      base  = rx_q.size();
      errs0 = n_par + n_frm + n_tmo + n_ovr;
      #(30*US)  ps2_clk = 1'b0;
      #(2*US)   ps2_clk = 1'b1;
      #(100*US);
      send_bits(make_frame(8'hC3, 1'b0, 1'b0), 11, 4);
      got = (rx_q.size() == base + 1) ? rx_q[base] : 8'hxx;
      checks++;
      if (got !== 8'hC3 || n_par + n_frm + n_tmo + n_ovr - errs0 !== 0) begin
         errors++;
         $display("[TB] FAIL glitch got %h errs=%0d exp c3 0", got, n_par + n_frm + n_tmo + n_ovr - errs0);
      end
      t0 = n_tmo;
      send_bits(make_frame(8'h99, 1'b0, 1'b0), 4, -1);
      #(3*US) reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rx_bus.out_valid, rx_bus.out_data, rx_bus.parity_err, rx_bus.frame_err,
           rx_bus.timeout_err, rx_bus.overrun} !== 13'h0) begin
         errors++;
         $display("[TB] FAIL midframe_reset got valid=%b data=%h exp 0 00", rx_bus.out_valid, rx_bus.out_data);
      end
      reset = 1'b0;
      #(2500*US);
      checks++;
      if (n_tmo - t0 !== 0) begin
         errors++;
         $display("[TB] FAIL reset_drops_frame got te=%0d exp 0", n_tmo - t0);
      end
      send_bits(make_frame(8'h7E, 1'b0, 1'b0), 11, -1);
      got = (rx_q.size() == base + 2) ? rx_q[base + 1] : 8'hxx;
      checks++;
      if (got !== 8'h7E) begin
         errors++;
         $display("[TB] FAIL after_reset got %h exp 7e", got);
      end
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$];
      logic [10:0] f;
      logic [7:0] got;
      int base, p0, f0, exp_p, exp_f, kind, idx;
      base  = rx_q.size();
      p0    = n_par;
      f0    = n_frm;
      exp_p = 0;
      exp_f = 0;
      for (int i = 0; i < 14; i++) begin
         kind = int'($urandom_range(0, 9));
         f = make_frame(8'($urandom), kind == 8, kind == 9);
         if ($urandom_range(0, 3) == 0) f[9] = ~f[9];
         case (frame_outcome(f))
            0: exp_q.push_back(f[8:1]);
            1: exp_f++;
            default: exp_p++;
         endcase
         send_bits(f, 11, -1);
         #(int'($urandom_range(0, 200)) * US);
      end
      checks++;
      if (rx_q.size() - base !== exp_q.size() || n_par - p0 !== exp_p || n_frm - f0 !== exp_f) begin
         errors++;
         $display("[TB] FAIL rand_counts got bytes=%0d pe=%0d fe=%0d exp %0d %0d %0d",
                  rx_q.size() - base, n_par - p0, n_frm - f0, exp_q.size(), exp_p, exp_f);
      end
      foreach (exp_q[k]) begin
         idx = base + k;
         got = (idx < rx_q.size()) ? rx_q[idx] : 8'hxx;
         checks++;
         if (got !== exp_q[k]) begin
            errors++;
            $display("[TB] FAIL rand_byte%0d got %h exp %h", k, got, exp_q[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_parity_error();
      test_frame_error();
      test_timeout();
      test_overrun();
      test_random();
      test_glitch_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
